if_fetch_unit: RTL
==================

# if_fetch_unit

Parametrised instruction-fetch stage for the ARM pipeline. It fetches sequential instructions from an instruction memory with a request/grant/response handshake and up to MAX_OUT requests in flight. Fetched instructions are buffered in a DEPTH-entry prefetch FIFO. The unit presents {PC+4, instruction} to decode, honours decode freeze, and redirects on taken branches by flushing the buffer and discarding stale responses.

## Interface
- N, 32, address/instruction width
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
- MAX_OUT, 2, max outstanding memory requests (1..DEPTH)
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  decode stall; head entry not consumed
- branch_taken  in  1  redirect request
- branch_addr  in  N  redirect target; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in-order)
- imem_rdata  in  N  response instruction
- valid_out  out  1  head entry valid
- pc_out  out  N  head entry address + 4
- instruction_out  out  N  head entry instruction

## Operation
- State: fetch_pc (N), FIFO count (0..DEPTH), outstanding (0..MAX_OUT), drop_cnt (0..MAX_OUT).
- Issue: imem_req = !branch_taken && outstanding < MAX_OUT && count + outstanding < DEPTH. imem_addr = fetch_pc. An ungranted request may be withdrawn or change address.
- Grant (req && gnt): fetch_pc += 4 (mod 2^N wrap), outstanding +1.
- Response (rvalid): outstanding −1. If drop_cnt > 0, the response is discarded and drop_cnt −1. Otherwise {addr+4, rdata} is pushed. The credit rule guarantees the FIFO is never full on a push.
- Consume: valid_out && !freeze pops the head.
- Outputs: valid_out = count ≠ 0. pc_out/instruction_out = head entry, or 0 when empty.
- Branch (highest priority): fetch_pc ← branch_addr & ~3 and the FIFO is flushed (count ← 0). No pop or push occurs that cycle. drop_cnt ← outstanding + grant_this_cycle − rvalid_this_cycle. A response arriving in the branch cycle belongs to the old stream and is discarded.
- Freeze does not stop fetching; fetching continues until credits run out.
- An rvalid with outstanding = 0 is a protocol error: it is ignored, and an assertion flags it.

## Timing
- Reset (rst low, asynchronous): fetch_pc = RESET_PC, count = outstanding = drop_cnt = 0, valid_out = 0, pc_out = instruction_out = 0, imem_req = 0.
- First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.
- Memory latency ≥1: rvalid arrives no earlier than the cycle after the grant.
- A push becomes visible at the outputs the cycle after rvalid (no bypass). With latency 1 and a grant at cycle 0, valid_out rises at cycle 2.
- Throughput is one instruction per cycle when MAX_OUT ≥ memory latency + 1 and freeze = 0.
- Simultaneous push and pop: count unchanged; the head advances.
- Reset mid-burst drops all in-flight state. The memory must tolerate abandoned requests.

## Structure
- Package if_pkg: fetch_entry_t {pc_plus4[N-1:0], instr[N-1:0]}, constant INSTR_BYTES = 4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, head output, and async active-low reset.
- Top module holds fetch_pc, the credit/outstanding/drop counters, and the issue logic.

## Test plan
- Reset release, latency-1 memory with gnt always 1 → addresses 0,4,8,… issued. From cycle 2: valid_out = 1 with pc_out = 4, 8, 12, … one per cycle.
- freeze held 6 cycles, DEPTH = 4, MAX_OUT = 2 → at most 4 entries buffered, imem_req drops to 0. Release → entries drain in order with none lost or duplicated.
- branch_taken with branch_addr = 0x103 while 2 requests are outstanding → FIFO empties. The next 2 responses are discarded. The next issue is addr 0x100, and the first valid entry has pc_out = 0x104.
- branch_taken in the same cycle as rvalid and a grant → drop_cnt accounts for both. Only responses for addresses ≥ target reach the outputs.
- imem_gnt held low for 5 cycles → imem_req stays 1 with a stable address, and fetch_pc does not advance.
- fetch_pc = 0xFFFFFFFC, N = 32 → the next address wraps to 0x0, and the entry shows pc_out = 0x0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: the prefetch entry and instruction size.
// Pure declarations; no latency or backpressure of its own.
package if_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: push/pop/flush FIFO of fetch entries; a push is visible at head one cycle later.
// Never refuses a pop of a valid head; upstream credit accounting keeps pushes away from a full buffer.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  entry_t                     push_dat,
  input  logic                       pop_vld,
  input  logic                       flush_vld,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over everything so a redirect never leaves a stale entry behind.
  assign do_push = push_vld && !flush_vld && (int'(count) < DEPTH);
  assign do_pop  = pop_vld && !flush_vld && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_vld) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push_vld && !flush_vld && int'(count) == DEPTH));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: credit-limited sequential requests into a prefetch FIFO; response-to-output latency 1 cycle.
// Decode freeze holds the head while fetch continues until FIFO+in-flight credits are exhausted; branches flush and drop stale responses.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int           N        = 32,
  parameter int           DEPTH    = 4,
  parameter int           MAX_OUT  = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_addr,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         valid_out,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] instruction_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [N-1:0] pc_plus4;
    logic [N-1:0] instr;
  } entry_t;

  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  rsp_pc;
  logic [N-1:0]  target;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic          gnt_fire;
  logic          rsp_fire;
  logic          rsp_drop;
  logic          push_vld;
  logic          pop_vld;
  entry_t        push_dat;
  entry_t        head_dat;

  assign target = {branch_addr[N-1:2], 2'b00};

  // Slots in the FIFO are reserved at issue time, so a response always finds room.
  assign imem_req  = rst && !branch_taken
                   && (int'(outstanding) < MAX_OUT)
                   && (int'(count) + int'(outstanding) < DEPTH);
  assign imem_addr = fetch_pc;

  assign gnt_fire = imem_req && imem_gnt;
  // A response with nothing in flight is a protocol violation and is ignored.
  assign rsp_fire = imem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp_fire && ((drop_cnt != '0) || branch_taken);
  assign push_vld = rsp_fire && !rsp_drop;
  assign pop_vld  = valid_out && !freeze && !branch_taken;

  assign outstanding_nxt = outstanding + OW'(gnt_fire) - OW'(rsp_fire);

  // rsp_pc tracks the address of the next response that will actually be kept.
  assign push_dat.pc_plus4 = rsp_pc + N'(INSTR_BYTES);
  assign push_dat.instr    = imem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_taken) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + N'(INSTR_BYTES);
        if (push_vld) rsp_pc <= rsp_pc + N'(INSTR_BYTES);
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_dat  (push_dat),
    .pop_vld   (pop_vld),
    .flush_vld (branch_taken),
    .count     (count),
    .head_dat  (head_dat)
  );

  assign valid_out       = (count != '0);
  assign pc_out          = head_dat.pc_plus4;
  assign instruction_out = head_dat.instr;

  a_rvalid_in_flight: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && outstanding == '0));

endmodule
